// File: rtl/spdif_encoder.sv
// S/PDIF (IEC 60958) transmitter: 24-bit stereo pairs in, biphase-mark serial stream out.
// One BMC cell per cell_ena_i strobe, 128 cells per frame, 192 frames per channel-status block.
module spdif_encoder #(
  parameter int FRAMES_PER_BLOCK = 192
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cell_ena_i,
  input  logic [23:0] left_i,
  input  logic [23:0] right_i,
  input  logic        user_i,
  input  logic        chstat_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        spdif_o,
  output logic        frame_start_o,
  output logic        block_start_o,
  output logic        underrun_o
);

  localparam int FW = (FRAMES_PER_BLOCK > 1) ? $clog2(FRAMES_PER_BLOCK) : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES_PER_BLOCK - 1);

  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  logic [6:0]    cell_cnt_q,    cell_cnt_d;
  logic [FW-1:0] frame_cnt_q,   frame_cnt_d;
  logic          hold_full_q,   hold_full_d;
  logic [23:0]   hold_left_q,   hold_left_d;
  logic [23:0]   hold_right_q,  hold_right_d;
  logic          hold_u_q,      hold_u_d;
  logic          hold_c_q,      hold_c_d;
  logic          ready_q,       ready_d;
  logic [23:0]   frm_left_q,    frm_left_d;
  logic [23:0]   frm_right_q,   frm_right_d;
  logic          frm_u_q,       frm_u_d;
  logic          frm_c_q,       frm_c_d;
  logic          frm_v_q,       frm_v_d;
  logic          spdif_q,       spdif_d;
  logic          last_level_q,  last_level_d;
  logic          frame_start_q, frame_start_d;
  logic          block_start_q, block_start_d;
  logic          underrun_q,    underrun_d;

  logic          accept;
  logic          boundary;
  logic          sub_right;
  logic [4:0]    slot;
  logic [23:0]   sample;
  logic [31:0]   slot_word;
  logic [7:0]    pattern;
  logic          pre_ref;
  logic          line_next;

  always_comb begin
    cell_cnt_d    = cell_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    hold_full_d   = hold_full_q;
    hold_left_d   = hold_left_q;
    hold_right_d  = hold_right_q;
    hold_u_d      = hold_u_q;
    hold_c_d      = hold_c_q;
    frm_left_d    = frm_left_q;
    frm_right_d   = frm_right_q;
    frm_u_d       = frm_u_q;
    frm_c_d       = frm_c_q;
    frm_v_d       = frm_v_q;
    spdif_d       = spdif_q;
    last_level_d  = last_level_q;
    frame_start_d = 1'b0;
    block_start_d = 1'b0;
    underrun_d    = 1'b0;

    accept    = valid_i & ready_q;
    boundary  = cell_ena_i & (cell_cnt_q == 7'd0);
    sub_right = cell_cnt_q[6];
    slot      = cell_cnt_q[5:1];
    sample    = sub_right ? frm_right_q : frm_left_q;

    // Slot-indexed subframe word: bit n is the value carried by slot n (preamble slots unused).
    slot_word = {^{frm_c_q, frm_u_q, frm_v_q, sample}, frm_c_q, frm_u_q, frm_v_q, sample, 4'b0000};

    if (sub_right) begin
      pattern = PRE_W;
    end else if (frame_cnt_q == '0) begin
      pattern = PRE_B;
    end else begin
      pattern = PRE_M;
    end

    // On the first preamble cell the prior level is still on the line; later cells use the latched copy.
    pre_ref = (cell_cnt_q[5:0] == 6'd0) ? spdif_q : last_level_q;

    if (cell_cnt_q[5:3] == 3'd0) begin
      line_next = pattern[3'd7 - cell_cnt_q[2:0]] ^ pre_ref;
    end else if (!cell_cnt_q[0]) begin
      line_next = ~spdif_q;
    end else begin
      line_next = slot_word[slot] ? ~spdif_q : spdif_q;
    end

    if (boundary) begin
      frame_start_d = 1'b1;
      block_start_d = (frame_cnt_q == '0);
      underrun_d    = ~hold_full_q;
      if (hold_full_q) begin
        frm_left_d  = hold_left_q;
        frm_right_d = hold_right_q;
        frm_u_d     = hold_u_q;
        frm_c_d     = hold_c_q;
        frm_v_d     = 1'b0;
        hold_full_d = 1'b0;
      end else begin
        frm_left_d  = '0;
        frm_right_d = '0;
        frm_u_d     = 1'b0;
        frm_c_d     = 1'b0;
        frm_v_d     = 1'b1;
      end
    end

    // A pair accepted on the boundary strobe lands in the holding register and waits a frame.
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_left_d  = left_i;
      hold_right_d = right_i;
      hold_u_d     = user_i;
      hold_c_d     = chstat_i;
    end

    ready_d = ~hold_full_d;

    if (cell_ena_i) begin
      spdif_d    = line_next;
      cell_cnt_d = cell_cnt_q + 7'd1;
      if (cell_cnt_q[5:0] == 6'd0) begin
        last_level_d = spdif_q;
      end
      if (cell_cnt_q == 7'd127) begin
        frame_cnt_d = (frame_cnt_q == LAST_FRAME) ? '0 : frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cell_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      hold_full_q   <= 1'b0;
      hold_left_q   <= '0;
      hold_right_q  <= '0;
      hold_u_q      <= 1'b0;
      hold_c_q      <= 1'b0;
      ready_q       <= 1'b1;
      frm_left_q    <= '0;
      frm_right_q   <= '0;
      frm_u_q       <= 1'b0;
      frm_c_q       <= 1'b0;
      frm_v_q       <= 1'b0;
      spdif_q       <= 1'b0;
      last_level_q  <= 1'b0;
      frame_start_q <= 1'b0;
      block_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      cell_cnt_q    <= cell_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      hold_full_q   <= hold_full_d;
      hold_left_q   <= hold_left_d;
      hold_right_q  <= hold_right_d;
      hold_u_q      <= hold_u_d;
      hold_c_q      <= hold_c_d;
      ready_q       <= ready_d;
      frm_left_q    <= frm_left_d;
      frm_right_q   <= frm_right_d;
      frm_u_q       <= frm_u_d;
      frm_c_q       <= frm_c_d;
      frm_v_q       <= frm_v_d;
      spdif_q       <= spdif_d;
      last_level_q  <= last_level_d;
      frame_start_q <= frame_start_d;
      block_start_q <= block_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign ready_o       = ready_q;
  assign spdif_o       = spdif_q;
  assign frame_start_o = frame_start_q;
  assign block_start_o = block_start_q;
  assign underrun_o    = underrun_q;

endmodule

// File: tb/tb_spdif_encoder.sv
// Self-checking bench for spdif_encoder: accepted pairs feed a queue-based frame model,
// and a monitor decodes the BMC line back into preambles and slot bits and compares.
module tb_spdif_encoder;

  localparam int FPB = 192;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cell_ena_i;
  logic [23:0] left_i;
  logic [23:0] right_i;
  logic        user_i;
  logic        chstat_i;
  logic        valid_i;
  logic        ready_o;
  logic        spdif_o;
  logic        frame_start_o;
  logic        block_start_o;
  logic        underrun_o;

  spdif_encoder #(.FRAMES_PER_BLOCK(FPB)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cell_ena_i    (cell_ena_i),
    .left_i        (left_i),
    .right_i       (right_i),
    .user_i        (user_i),
    .chstat_i      (chstat_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .spdif_o       (spdif_o),
    .frame_start_o (frame_start_o),
    .block_start_o (block_start_o),
    .underrun_o    (underrun_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        u;
    logic        c;
    logic        v;
    int          fno;
  } frame_t;

  frame_t pend_q[$];
  frame_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // monitor-side state
  int     cell_idx = 0;
  int     frame_no = 0;
  int     frames_done = 0;
  int     bs_count = 0;
  int     ur_count = 0;
  logic   line_lvl = 1'b0;
  logic   frame_prior = 1'b0;
  logic   cells [0:127];
  logic   s_rst, s_ena, s_acc;
  logic   exp_fs, exp_bs, exp_ur;
  frame_t s_pair, cur;

  // driver-side state
  int          pairs_left = 0;
  int          strobes_left = 0;
  int          ena_period = 1;
  int          phase = 0;
  int          data_mode = 0;
  logic        rand_valid = 1'b0;
  logic        ready_prev = 1'b0;
  logic [23:0] inc_val = 24'd1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decode one captured frame: preamble cells, a transition at every slot start, and the slot bits.
  task automatic checkFrame(input frame_t f);
    for (int sub = 0; sub < 2; sub++) begin
      int          base;
      logic [7:0]  pat, got;
      logic        prior, lvl, bmc_ok, a, b;
      logic [27:0] word, want;
      logic [23:0] s;
      base  = sub * 64;
      prior = (sub == 0) ? frame_prior : cells[63];
      if (sub == 1)                pat = 8'b11100100;
      else if ((f.fno % FPB) == 0) pat = 8'b11101000;
      else                         pat = 8'b11100010;
      for (int k = 0; k < 8; k++) got[7-k] = cells[base+k];
      checkOutput(sub == 0 ? "left_preamble" : "right_preamble", 64'(got), 64'(pat ^ {8{prior}}));
      lvl    = cells[base+7];
      bmc_ok = 1'b1;
      word   = '0;
      for (int sl = 4; sl < 32; sl++) begin
        a = cells[base + 2*sl];
        b = cells[base + 2*sl + 1];
        if (a == lvl) bmc_ok = 1'b0;
        word[sl-4] = a ^ b;
        lvl = b;
      end
      s = (sub == 0) ? f.l : f.r;
      want[23:0] = s;
      want[24]   = f.v;
      want[25]   = f.u;
      want[26]   = f.c;
      want[27]   = ($countones({f.c, f.u, f.v, s}) % 2) == 1;
      checkOutput(sub == 0 ? "left_slot_transitions" : "right_slot_transitions", 64'(bmc_ok), 64'd1);
      checkOutput(sub == 0 ? "left_word" : "right_word", 64'(word), 64'(want));
    end
  endtask

  // Monitor: model update on each rising edge, output comparison 1 ns later.
  initial begin
    forever begin
      @(posedge clk_i);
      s_rst = rst_i;
      s_ena = cell_ena_i;
      s_acc = valid_i & ready_o;
      s_pair.l = left_i;
      s_pair.r = right_i;
      s_pair.u = user_i;
      s_pair.c = chstat_i;
      s_pair.v = 1'b0;
      s_pair.fno = 0;
      exp_fs = 1'b0;
      exp_bs = 1'b0;
      exp_ur = 1'b0;
      if (s_rst) begin
        pend_q.delete();
        exp_q.delete();
        cell_idx = 0;
        frame_no = 0;
      end else begin
        if (s_ena && cell_idx == 0) begin
          exp_fs = 1'b1;
          exp_bs = (frame_no % FPB) == 0;
          if (pend_q.size() > 0) begin
            cur = pend_q.pop_front();
            cur.v = 1'b0;
          end else begin
            cur = '{l: 24'd0, r: 24'd0, u: 1'b0, c: 1'b0, v: 1'b1, fno: 0};
            exp_ur = 1'b1;
          end
          cur.fno = frame_no;
          exp_q.push_back(cur);
        end
        if (s_acc) pend_q.push_back(s_pair);
      end
      #1;
      if (s_rst) begin
        checkOutput("reset_spdif", 64'(spdif_o), 64'd0);
        checkOutput("reset_ready", 64'(ready_o), 64'd1);
        checkOutput("reset_pulses", 64'({frame_start_o, block_start_o, underrun_o}), 64'd0);
        line_lvl = 1'b0;
      end else begin
        checkOutput("pulses", 64'({frame_start_o, block_start_o, underrun_o}),
                    64'({exp_fs, exp_bs, exp_ur}));
        checkOutput("ready", 64'(ready_o), 64'(pend_q.size() == 0));
        if (block_start_o) bs_count++;
        if (underrun_o)    ur_count++;
        if (s_ena) begin
          if (cell_idx == 0) frame_prior = line_lvl;
          cells[cell_idx] = spdif_o;
          cell_idx++;
          if (cell_idx == 128) begin
            cell_idx = 0;
            frame_no++;
            frames_done++;
            checkOutput("frame_queued", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) checkFrame(exp_q.pop_front());
          end
        end else begin
          checkOutput("line_hold", 64'(spdif_o), 64'(line_lvl));
        end
        line_lvl = spdif_o;
      end
    end
  end

  // Drive one clock of stimulus per loop: offer pairs while any remain, issue strobes while budget remains.
  task automatic applyStimulus(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk_i);
      if (valid_i && ready_prev) begin
        valid_i = 1'b0;
        pairs_left--;
      end
      if (!valid_i && pairs_left > 0 && (!rand_valid || $urandom_range(0, 2) == 0)) begin
        valid_i = 1'b1;
        if (data_mode == 0) begin
          left_i   = 24'($urandom);
          right_i  = 24'($urandom);
          user_i   = 1'($urandom);
          chstat_i = 1'($urandom);
        end else if (data_mode == 1) begin
          left_i   = inc_val;
          right_i  = ~inc_val;
          user_i   = inc_val[0];
          chstat_i = inc_val[1];
          inc_val  = inc_val + 24'd1;
        end
      end
      ready_prev = ready_o;
      if (strobes_left > 0 &&
          ((ena_period == 0) ? ($urandom_range(0, 1) == 1) : ((phase % ena_period) == 0))) begin
        cell_ena_i = 1'b1;
        strobes_left--;
      end else begin
        cell_ena_i = 1'b0;
      end
      phase++;
    end
  endtask

  // One-clock reset with a strobe present, so reset must win over line activity.
  task automatic applyReset();
    @(negedge clk_i);
    rst_i      = 1'b1;
    valid_i    = 1'b0;
    cell_ena_i = 1'b1;
    pairs_left = 0;
    strobes_left = 0;
    @(negedge clk_i);
    rst_i      = 1'b0;
    cell_ena_i = 1'b0;
    ready_prev = ready_o;
    phase      = 0;
  endtask

  int bs0, ur0, fr0;

  initial begin
    rst_i = 1'b1; cell_ena_i = 1'b0; valid_i = 1'b0;
    left_i = '0; right_i = '0; user_i = 1'b0; chstat_i = 1'b0;
    applyReset();

    // Single known pair, then an underrun frame.
    applyReset();
    left_i = 24'h123456; right_i = 24'hABCDEF; user_i = 1'b0; chstat_i = 1'b1;
    data_mode = 2; rand_valid = 1'b0; ena_period = 1; pairs_left = 1;
    applyStimulus(3);
    bs0 = bs_count; ur0 = ur_count;
    strobes_left = 256;
    applyStimulus(260);
    checkOutput("t1_block_starts", 64'(bs_count - bs0), 64'd1);
    checkOutput("t1_underruns", 64'(ur_count - ur0), 64'd1);
    checkOutput("t1_frames_complete", 64'(exp_q.size()), 64'd0);

    // 193 random pairs across a block wrap.
    applyReset();
    data_mode = 0; pairs_left = 193;
    applyStimulus(3);
    bs0 = bs_count; ur0 = ur_count; fr0 = frames_done;
    strobes_left = 193 * 128;
    applyStimulus(193 * 128 + 4);
    checkOutput("t2_block_starts", 64'(bs_count - bs0), 64'd2);
    checkOutput("t2_underruns", 64'(ur_count - ur0), 64'd0);
    checkOutput("t2_frames", 64'(frames_done - fr0), 64'd193);
    checkOutput("t2_pairs_consumed", 64'(pairs_left), 64'd0);

    // No data at all.
    applyReset();
    ur0 = ur_count;
    strobes_left = 3 * 128;
    applyStimulus(3 * 128 + 4);
    checkOutput("t3_underruns", 64'(ur_count - ur0), 64'd3);

    // valid_i held high with incrementing data; first load collides with the first boundary.
    applyReset();
    data_mode = 1; inc_val = 24'd1; pairs_left = 1000;
    ur0 = ur_count;
    strobes_left = 4 * 128;
    applyStimulus(4 * 128 + 4);
    checkOutput("t4_accepted", 64'(1000 - pairs_left), 64'd4);
    checkOutput("t4_underruns", 64'(ur_count - ur0), 64'd1);
    checkOutput("t4_frames_complete", 64'(exp_q.size()), 64'd0);

    // Strobe every third clock, reset after cell 40, then restart with B.
    applyReset();
    data_mode = 0; ena_period = 3; pairs_left = 2;
    strobes_left = 41;
    applyStimulus(3 * 41 + 2);
    checkOutput("t6_strobes_issued", 64'(strobes_left), 64'd0);
    checkOutput("t6_cell_before_reset", 64'(cell_idx), 64'd41);
    applyReset();
    bs0 = bs_count;
    strobes_left = 128;
    applyStimulus(3 * 128 + 4);
    checkOutput("t6_block_starts", 64'(bs_count - bs0), 64'd1);
    checkOutput("t6_frames_complete", 64'(exp_q.size()), 64'd0);

    // Random strobe gaps and random valid gaps.
    applyReset();
    data_mode = 0; rand_valid = 1'b1; ena_period = 0; pairs_left = 1000;
    strobes_left = 6 * 128;
    applyStimulus(4000);
    checkOutput("t7_strobes_done", 64'(strobes_left), 64'd0);
    checkOutput("t7_frames_complete", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
